instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 123 ++++++++++++
 tb/tb_instruction_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a PC register drives a combinational ROM, and fetched words go into a small FIFO.
// A null word halts fetching, and a redirect flushes the queue and restarts fetch.
module instruction_fetch #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   output logic [7:0]  imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [7:0]  redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [7:0]  out_pc,
   output logic        halted
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [0:0] {
      FETCH  = 1'b0,
      HALTED = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [39:0]   mem_q [DEPTH];

   logic push_s;
   logic pop_s;
   logic full_s;

   assign pop_s  = (count_q != '0) && out_ready;
   assign full_s = (count_q == CW'(DEPTH));

   // Next-state: redirect has priority, then the fetch/halt decision, then FIFO bookkeeping
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      push_s  = 1'b0;
      if (redirect_valid) begin
         pc_d    = redirect_pc & 8'hFC;
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
         state_d = FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (fetch_en && (imem_rdata == 32'h0)) begin
                  state_d = HALTED;
               end else if (fetch_en && (!full_s || pop_s)) begin
                  push_s = 1'b1;
               end else begin
                  push_s = 1'b0;
               end
            end
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
         endcase
         if (push_s) begin
            pc_d   = pc_q + 8'd4;
            tail_d = tail_q + PW'(1);
         end else begin
            pc_d   = pc_q;
         end
         if (pop_s) begin
            head_d = head_q + PW'(1);
         end else begin
            head_d = head_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         count_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Queue storage; cleared on reset so the head reads zero until the first push
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= 40'h0;
         end
      end else if (push_s) begin
         mem_q[tail_q] <= {pc_q, imem_rdata};
      end
   end

   assign imem_addr            = pc_q;
   assign out_valid            = (count_q != '0);
   assign {out_pc, out_instr}  = mem_q[head_q];
   assign halted               = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch driven by the 7-word test ROM.
// Each row applies inputs for one clock edge and checks the outputs just after that edge.
module tb_instruction_fetch;

   logic        clk;
   logic        rst;
   logic        fetch_en;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [7:0]  out_pc;
   logic        halted;

   int total;
   int bad;

   typedef struct {
      logic        rst;
      logic        fe;
      logic        rdy;
      logic        rv;
      logic [7:0]  rpc;
      logic        ev;
      logic        chk;
      logic [7:0]  epc;
      logic [31:0] einstr;
      logic        eh;
      logic [7:0]  eaddr;
   } vec_t;

   vec_t vecs[$];

   instruction_fetch #(.RESET_PC(8'h00), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Test ROM, with one extra nonzero word at 0xFC for the wrap case
   always_comb begin
      case (imem_addr)
         8'h00:   imem_rdata = 32'h00700093;
         8'h04:   imem_rdata = 32'h00300193;
         8'h08:   imem_rdata = 32'hFFF00113;
         8'h0C:   imem_rdata = 32'h00110113;
         8'h10:   imem_rdata = 32'h003123B3;
         8'h14:   imem_rdata = 32'hFE208AE3;
         8'h18:   imem_rdata = 32'hFE000AE3;
         8'hFC:   imem_rdata = 32'h00000013;
         default: imem_rdata = 32'h0;
      endcase
   end

   task automatic add(input logic r, input logic fe, input logic rdy, input logic rv,
                      input logic [7:0] rpc, input logic ev, input logic chk,
                      input logic [7:0] epc, input logic [31:0] ei, input logic eh,
                      input logic [7:0] ea);
      vec_t v;
      v.rst = r; v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
      v.ev = ev; v.chk = chk; v.epc = epc; v.einstr = ei; v.eh = eh; v.eaddr = ea;
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 8'h00;

      // free-run
      add(1,0,0,0,8'h00, 0,1,8'h00,32'h0,       0,8'h00);
      add(0,1,1,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h04);
      add(0,1,1,0,8'h00, 1,1,8'h04,32'h00300193,0,8'h08);
      add(0,1,1,0,8'h00, 1,1,8'h08,32'hFFF00113,0,8'h0C);
      add(0,1,1,0,8'h00, 1,1,8'h0C,32'h00110113,0,8'h10);
      add(0,1,1,0,8'h00, 1,1,8'h10,32'h003123B3,0,8'h14);
      add(0,1,1,0,8'h00, 1,1,8'h14,32'hFE208AE3,0,8'h18);
      add(0,1,1,0,8'h00, 1,1,8'h18,32'hFE000AE3,0,8'h1C);
      add(0,1,1,0,8'h00, 0,0,8'h00,32'h0,       1,8'h1C);
      add(0,1,1,0,8'h00, 0,0,8'h00,32'h0,       1,8'h1C);
      // backpressure from reset
      add(1,1,1,0,8'h00, 0,1,8'h00,32'h0,       0,8'h00);
      add(0,1,0,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h04);
      add(0,1,0,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h08);
      add(0,1,0,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h08);
      add(0,1,0,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h08);
      add(0,1,1,0,8'h00, 1,1,8'h04,32'h00300193,0,8'h0C);
      add(0,1,1,0,8'h00, 1,1,8'h08,32'hFFF00113,0,8'h10);
      // redirect while full
      add(0,1,0,1,8'h0C, 0,0,8'h00,32'h0,       0,8'h0C);
      add(0,1,1,0,8'h00, 1,1,8'h0C,32'h00110113,0,8'h10);
      add(0,1,1,0,8'h00, 1,1,8'h10,32'h003123B3,0,8'h14);
      // run to halt, then misaligned redirect out of HALTED
      add(0,1,1,0,8'h00, 1,1,8'h14,32'hFE208AE3,0,8'h18);
      add(0,1,1,0,8'h00, 1,1,8'h18,32'hFE000AE3,0,8'h1C);
      add(0,1,1,0,8'h00, 0,0,8'h00,32'h0,       1,8'h1C);
      add(0,1,1,1,8'h0F, 0,0,8'h00,32'h0,       0,8'h0C);
      add(0,1,1,0,8'h00, 1,1,8'h0C,32'h00110113,0,8'h10);
      // fetch_en low holds pc
      add(0,0,1,0,8'h00, 0,0,8'h00,32'h0,       0,8'h10);
      add(0,1,1,0,8'h00, 1,1,8'h10,32'h003123B3,0,8'h14);
      // wrap at 0xFC
      add(0,1,1,1,8'hFC, 0,0,8'h00,32'h0,       0,8'hFC);
      add(0,1,1,0,8'h00, 1,1,8'hFC,32'h00000013,0,8'h00);
      add(0,1,1,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h04);
      // fill, then reset overriding redirect and handshake
      add(0,1,0,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h08);
      add(0,1,0,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h08);
      add(1,1,1,1,8'h10, 0,1,8'h00,32'h0,       0,8'h00);
      add(0,1,1,0,8'h00, 1,1,8'h00,32'h00700093,0,8'h04);
      // pop coincident with redirect
      add(0,1,1,1,8'h08, 0,0,8'h00,32'h0,       0,8'h08);
      add(0,1,1,0,8'h00, 1,1,8'h08,32'hFFF00113,0,8'h0C);

      foreach (vecs[i]) begin
         rst            = vecs[i].rst;
         fetch_en       = vecs[i].fe;
         out_ready      = vecs[i].rdy;
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         tick();
         check32($sformatf("v%0d out_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ev});
         check32($sformatf("v%0d halted", i),    {31'h0, halted},    {31'h0, vecs[i].eh});
         check32($sformatf("v%0d imem_addr", i), {24'h0, imem_addr}, {24'h0, vecs[i].eaddr});
         if (vecs[i].chk) begin
            check32($sformatf("v%0d out_pc", i),    {24'h0, out_pc}, {24'h0, vecs[i].epc});
            check32($sformatf("v%0d out_instr", i), out_instr,       vecs[i].einstr);
         end
      end

      // Drain with fetch disabled, bounded wait
      rst = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0; out_ready = 1'b1;
      begin
         int n;
         n = 0;
         tick();
         while (out_valid && n < 10) begin
            tick();
            n++;
         end
         check32("drain timeout", {31'h0, out_valid}, 32'h0);
         check32("drain addr", {24'h0, imem_addr}, 32'h0000000C);
      end

      // Head must stay put under sustained backpressure while the queue fills
      fetch_en = 1'b1; out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check32($sformatf("stall%0d out_pc", k), {24'h0, out_pc}, 32'h0000000C);
         check32($sformatf("stall%0d out_instr", k), out_instr, 32'h00110113);
      end
      check32("stall addr", {24'h0, imem_addr}, 32'h00000014);

      // Release: remaining entries arrive in order without duplicates
      out_ready = 1'b1;
      tick();
      check32("release out_pc", {24'h0, out_pc}, 32'h00000010);
      tick();
      check32("release2 out_pc", {24'h0, out_pc}, 32'h00000014);
      check32("release2 out_instr", out_instr, 32'hFE208AE3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
